// File: rtl/fusion_sched.sv
// rtl/fusion_sched.sv - IMU/LiDAR pairing sequencer for the fusion_top Kalman core
//
// Buffers one IMU and one LiDAR sample (newest wins), pairs them within PAIR_WINDOW
// cycles, issues one start/valid transaction per pair to the core, waits up to
// TIMEOUT_CYCLES for its done, and holds the returned state vector for a
// valid/ready consumer.
//
// Optional feature macro: FUSION_SCHED_STATS_EN adds pair_cnt and tmo_cnt outputs.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imu_valid/ready/data      IMU sample input (ready is 1 whenever not in reset)
//   lidar_valid/ready/data    LiDAR sample input (ready is 1 whenever not in reset)
//   core_start, core_valid    one-cycle issue pulse to the core
//   core_imu, core_lidar      paired samples presented with the issue pulse
//   core_done, core_state     core result strobe and state vector (element 0 in LSBs)
//   res_valid/ready/state     held result towards the consumer
//   err_timeout               one-cycle pulse when the core fails to answer
//   drop_cnt                  saturating count of discarded samples
//   pair_cnt, tmo_cnt         saturating issue / timeout counts (stats build only)
module fusion_sched #(
   parameter int DATA_WIDTH     = 16,
   parameter int STATE_WIDTH    = 2,
   parameter int PAIR_WINDOW    = 64,
   parameter int TIMEOUT_CYCLES = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              imu_valid,
   output logic                              imu_ready,
   input  logic [DATA_WIDTH-1:0]             imu_data,
   input  logic                              lidar_valid,
   output logic                              lidar_ready,
   input  logic [DATA_WIDTH-1:0]             lidar_data,
   output logic                              core_start,
   output logic                              core_valid,
   output logic [DATA_WIDTH-1:0]             core_imu,
   output logic [DATA_WIDTH-1:0]             core_lidar,
   input  logic                              core_done,
   input  logic [STATE_WIDTH*DATA_WIDTH-1:0] core_state,
   output logic                              res_valid,
   input  logic                              res_ready,
   output logic [STATE_WIDTH*DATA_WIDTH-1:0] res_state,
   output logic                              err_timeout,
`ifdef FUSION_SCHED_STATS_EN
   output logic [15:0]                       drop_cnt,
   output logic [15:0]                       pair_cnt,
   output logic [15:0]                       tmo_cnt
`else
   output logic [15:0]                       drop_cnt
`endif
);

   localparam int AW = $clog2(PAIR_WINDOW + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

   state_t                state;
   logic                  imu_full;
   logic                  lidar_full;
   logic [DATA_WIDTH-1:0] imu_buf;
   logic [DATA_WIDTH-1:0] lidar_buf;
   logic [AW-1:0]         age;
   logic [TW-1:0]         tmo;

   logic                  issue_clr;
   logic                  lone;
   logic                  expire;
   logic                  imu_expire;
   logic                  lidar_expire;
   logic [1:0]            drops;
   logic [16:0]           drop_sum;

   assign imu_ready   = ~rst;
   assign lidar_ready = ~rst;

   always_comb begin
      issue_clr = (state == ISSUE);
      lone      = imu_full ^ lidar_full;
      expire    = lone && (age == AW'(PAIR_WINDOW - 1));
      // A partner arriving on the expiry cycle rescues the lone sample.
      imu_expire   = expire && imu_full   && !lidar_valid;
      lidar_expire = expire && lidar_full && !imu_valid;
      // Overwrite of a full buffer is a drop unless ISSUE is emptying it anyway;
      // an expiring sample replaced by a same-cycle capture counts only once.
      drops = 2'(imu_valid   && imu_full   && !issue_clr)
            + 2'(lidar_valid && lidar_full && !issue_clr)
            + 2'(imu_expire   && !imu_valid)
            + 2'(lidar_expire && !lidar_valid);
      drop_sum = {1'b0, drop_cnt} + 17'(drops);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         imu_full    <= 1'b0;
         lidar_full  <= 1'b0;
         imu_buf     <= '0;
         lidar_buf   <= '0;
         age         <= '0;
         tmo         <= '0;
         core_start  <= 1'b0;
         core_valid  <= 1'b0;
         core_imu    <= '0;
         core_lidar  <= '0;
         res_valid   <= 1'b0;
         res_state   <= '0;
         err_timeout <= 1'b0;
         drop_cnt    <= '0;
`ifdef FUSION_SCHED_STATS_EN
         pair_cnt    <= '0;
         tmo_cnt     <= '0;
`endif
      end else begin
         if (imu_valid) begin
            imu_full <= 1'b1;
            imu_buf  <= imu_data;
         end else if (issue_clr || imu_expire) begin
            imu_full <= 1'b0;
         end

         if (lidar_valid) begin
            lidar_full <= 1'b1;
            lidar_buf  <= lidar_data;
         end else if (issue_clr || lidar_expire) begin
            lidar_full <= 1'b0;
         end

         age      <= (lone && !expire) ? age + AW'(1) : '0;
         drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

         core_start  <= 1'b0;
         core_valid  <= 1'b0;
         err_timeout <= 1'b0;

         case (state)
            IDLE: begin
               if (imu_full && lidar_full) begin
                  state      <= ISSUE;
                  core_start <= 1'b1;
                  core_valid <= 1'b1;
                  // Present what the buffers hold during ISSUE, so a capture on
                  // this edge is the sample that gets issued.
                  core_imu   <= imu_valid   ? imu_data   : imu_buf;
                  core_lidar <= lidar_valid ? lidar_data : lidar_buf;
`ifdef FUSION_SCHED_STATS_EN
                  if (pair_cnt != 16'hFFFF) pair_cnt <= pair_cnt + 16'd1;
`endif
               end
            end
            ISSUE: begin
               state <= WAIT;
               tmo   <= '0;
            end
            WAIT: begin
               if (core_done) begin
                  res_state <= core_state;
                  res_valid <= 1'b1;
                  state     <= HOLD;
               end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                  err_timeout <= 1'b1;
                  state       <= IDLE;
`ifdef FUSION_SCHED_STATS_EN
                  if (tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 16'd1;
`endif
               end else begin
                  tmo <= tmo + TW'(1);
               end
            end
            HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
